seq_divider_nb: RTL

- Multi-cycle unsigned restoring divider producing quotient and remainder of two N-bit operands.
- Each iteration is one shift-subtract-with-borrow step: the inverse of the shift-add multiply path.
- Sits beside the combinational arithmetic ALU slice.
- Serves the message-decoding datapath wherever a div/mod result is needed, e.g. modular reduction of decoded words.

---
 rtl/seq_divider_pkg.sv | 18 +
 rtl/full_subtractor_nb.sv | 21 ++
 rtl/seq_divider_nb.sv | 111 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

    localparam int unsigned MAX_W = 64;

    // Quotient reported for a zero divisor: all ones across the low w bits.
    function automatic logic [MAX_W-1:0] zero_div_quotient(input int unsigned w);
        logic [MAX_W-1:0] q;
        q = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < w) q[i] = 1'b1;
        end
        return q;
    endfunction

endpackage

// File: rtl/full_subtractor_nb.sv
// W-bit ripple-style subtractor: diff = a - b - bin, bout set on underflow.
module full_subtractor_nb #(
    parameter int unsigned W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    logic [W:0] ext;

    always_comb begin
        ext = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    end

    assign diff = ext[W-1:0];
    assign bout = ext[W];

endmodule

// File: rtl/seq_divider_nb.sv
// Multi-cycle unsigned restoring divider: one shift-subtract step per clock.
module seq_divider_nb
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [MAX_W-1:0] QZ_WIDE = zero_div_quotient(N);
    localparam logic [N-1:0] QZ = QZ_WIDE[N-1:0];

    div_state_t     state;
    logic [N-1:0]   qreg;
    logic [N-1:0]   dreg;
    logic [N:0]     rem;
    logic [CW-1:0]  cnt;

    logic [N:0]     shifted;
    logic [N:0]     trial;
    logic           borrow;
    logic [N:0]     rem_next;
    logic [N-1:0]   q_next;

    // Upper half of {rem, qreg} << 1; rem[N] is always 0 so nothing is lost.
    always_comb begin
        shifted = (rem << 1) | {{N{1'b0}}, qreg[N-1]};
    end

    full_subtractor_nb #(
        .W(N + 1)
    ) u_sub (
        .a    (shifted),
        .b    ({1'b0, dreg}),
        .bin  (1'b0),
        .diff (trial),
        .bout (borrow)
    );

    always_comb begin
        rem_next = borrow ? shifted : trial;
        q_next   = {qreg[N-2:0], ~borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            qreg        <= '0;
            dreg        <= '0;
            rem         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        qreg        <= A;
                        dreg        <= B;
                        rem         <= '0;
                        div_by_zero <= 1'b0;
                        cnt         <= CW'(N);
                        if (B == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            Q           <= QZ;
                            R           <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    qreg <= q_next;
                    rem  <= rem_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        Q     <= q_next;
                        R     <= rem_next[N-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
